// File: rtl/game_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | game_pkg : shared types and helpers for the memory-game datapath      |
// | Rev 1.0  : initial release                                            |
// +-----------------------------------------------------------------------+
package game_pkg;

    localparam int IDX_W     = 3;
    localparam int LED_W     = 8;
    localparam int MAX_STEPS = 16;
    localparam int SEQ_W     = IDX_W * MAX_STEPS;
    localparam int STEP_W    = $clog2(MAX_STEPS);
    localparam int LEN_W     = $clog2(MAX_STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Level 0 is clamped to the shortest game; levels 4..7 all use the full pattern.
    function automatic logic [LEN_W-1:0] level_to_len(input logic [2:0] level);
        logic [LEN_W-1:0] len;
        case (level)
            3'd0, 3'd1: len = LEN_W'(4);
            3'd2:       len = LEN_W'(8);
            3'd3:       len = LEN_W'(12);
            default:    len = LEN_W'(16);
        endcase
        return len;
    endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/led_onehot_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | led_onehot_decoder : 3-bit step index to 8-bit one-hot LED pattern    |
// | Rev 1.0  : initial release                                            |
// +-----------------------------------------------------------------------+
module led_onehot_decoder
    import game_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    output logic [LED_W-1:0] o_led
);

    // Index k lights led[k], mirroring the button encoder on the capture side.
    for (genvar gi = 0; gi < LED_W; gi++) begin : g_bit
        assign o_led[gi] = (i_idx == IDX_W'(gi));
    end

endmodule : led_onehot_decoder
`default_nettype wire

// File: rtl/sequence_player.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sequence_player : plays a latched index pattern on the game LEDs      |
// | Rev 1.0  : initial release                                            |
// +-----------------------------------------------------------------------+
module sequence_player
    import game_pkg::*;
#(
    parameter int ON_CYCLES  = 24,
    parameter int OFF_CYCLES = 8
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2:0]           level,
    input  logic [SEQ_W-1:0]     seq,
    output logic [LED_W-1:0]     led,
    output logic [STEP_W-1:0]    step_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int c_MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int c_TMR_W   = $clog2(c_MAX_CYC + 1);
    localparam logic [c_TMR_W-1:0] c_ON_LOAD  = c_TMR_W'(ON_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_OFF_LOAD = c_TMR_W'(OFF_CYCLES - 1);

    state_t              r_state, w_state_nxt;
    logic [c_TMR_W-1:0]  r_timer, w_timer_nxt;
    logic [STEP_W-1:0]   r_step,  w_step_nxt;
    logic [LEN_W-1:0]    r_len,   w_len_nxt;
    logic [SEQ_W-1:0]    r_pattern, w_pattern_nxt;
    logic [LED_W-1:0]    r_led;
    logic                r_busy, r_done;
    logic                w_lit_nxt, w_busy_nxt, w_done_nxt;
    logic                w_last;
    logic [IDX_W-1:0]    w_idx;
    logic [LED_W-1:0]    w_onehot;

    assign w_last = ({1'b0, r_step} == (r_len - 1'b1));

    // Decode the index of the step that will be showing after this edge,
    // so the LED register lines up with the state register.
    assign w_idx = w_pattern_nxt[w_step_nxt * IDX_W +: IDX_W];

    led_onehot_decoder u_dec (
        .i_idx (w_idx),
        .o_led (w_onehot)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_step_nxt    = r_step;
        w_len_nxt     = r_len;
        w_pattern_nxt = r_pattern;
        w_lit_nxt     = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_nxt   = ON;
                    w_pattern_nxt = seq;
                    w_len_nxt     = level_to_len(level);
                    w_step_nxt    = '0;
                    w_timer_nxt   = c_ON_LOAD;
                    w_lit_nxt     = 1'b1;
                    w_busy_nxt    = 1'b1;
                end
            end
            ON: begin
                w_busy_nxt = 1'b1;
                if (r_timer == '0) begin
                    w_state_nxt = OFF;
                    w_timer_nxt = c_OFF_LOAD;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                    w_lit_nxt   = 1'b1;
                end
            end
            OFF: begin
                w_busy_nxt = 1'b1;
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - 1'b1;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                    w_timer_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ON;
                    w_step_nxt  = r_step + 1'b1;
                    w_timer_nxt = c_ON_LOAD;
                    w_lit_nxt   = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
                w_timer_nxt = '0;
            end
        endcase

        // Abort overrides everything outside IDLE, including the done pulse.
        if (abort && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_step_nxt  = '0;
            w_timer_nxt = '0;
            w_lit_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_step    <= '0;
            r_len     <= '0;
            r_pattern <= '0;
            r_led     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_step    <= w_step_nxt;
            r_len     <= w_len_nxt;
            r_pattern <= w_pattern_nxt;
            r_led     <= w_lit_nxt ? w_onehot : '0;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign led      = r_led;
    assign step_idx = r_step;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule : sequence_player
`default_nettype wire

// File: tb/tb_sequence_player.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sequence_player : randomized bench against a timeline model        |
// | Rev 1.0  : initial release                                            |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sequence_player;

    localparam int ON     = 24;
    localparam int OFF    = 8;
    localparam int CYC    = ON + OFF;
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_DONE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [2:0]  level;
    logic [47:0] seq;
    logic [7:0]  led;
    logic [3:0]  step_idx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase plus cycles elapsed since the first lit cycle.
    int          m_phase;
    int          m_e;
    int          m_len;
    logic [47:0] m_pat;
    bit          m_zero;

    sequence_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .level    (level),
        .seq      (seq),
        .led      (led),
        .step_idx (step_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int len_of(input logic [2:0] lv);
        if (lv == 3'd0) return 4;
        if (lv >= 3'd4) return 16;
        return 4 * int'(lv);
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        m_e     = 0;
        m_zero  = 1'b1;
    endtask

    task automatic model_update();
        if (!rst) begin
            model_reset();
        end else begin
            case (m_phase)
                M_IDLE: if (start && !abort) begin
                    m_phase = M_PLAY;
                    m_e     = 0;
                    m_pat   = seq;
                    m_len   = len_of(level);
                end
                M_PLAY: if (abort) begin
                    m_phase = M_IDLE;
                    m_zero  = 1'b1;
                end else begin
                    m_e++;
                    if (m_e == m_len * CYC) m_phase = M_DONE;
                end
                default: begin
                    m_phase = M_IDLE;
                    m_zero  = 1'b0;
                end
            endcase
        end
    endtask

    task automatic compare();
        logic [7:0] e_led;
        logic       e_busy;
        logic       e_done;
        int         e_idx;
        bit         idx_chk;
        e_led   = 8'h00;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_idx   = 0;
        idx_chk = m_zero;
        if (m_phase == M_PLAY) begin
            e_idx   = m_e / CYC;
            e_busy  = 1'b1;
            idx_chk = 1'b1;
            if ((m_e % CYC) < ON) e_led = 8'(1) << m_pat[3*e_idx +: 3];
        end else if (m_phase == M_DONE) begin
            e_done  = 1'b1;
            e_idx   = m_len - 1;
            idx_chk = 1'b1;
        end
        check_eq("led",  32'(led),  32'(e_led));
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("done", 32'(done), 32'(e_done));
        if (idx_chk) check_eq("step_idx", 32'(step_idx), 32'(e_idx));
        check_eq("onehot", 32'($countones(led) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic play(input logic [2:0] lv, input logic [47:0] pat, input bit scramble,
                        input int abort_at, input int rst_at, input int extra_at,
                        input bit start_in_done, output int dcnt, output int dlat);
        int guard;
        int lat;
        level = lv;
        seq   = pat;
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        dcnt  = 0;
        dlat  = -1;
        guard = 0;
        while (m_phase != M_IDLE && guard < 1000) begin
            guard++;
            if (rst_at >= 0 && m_phase == M_PLAY && m_e == rst_at) begin
                rst = 1'b0;
                #1;
                model_reset();
                compare();
                tick();
                tick();
                rst = 1'b1;
                break;
            end
            if (scramble) seq = {16'($urandom), $urandom};
            abort = (m_phase == M_PLAY && m_e == abort_at);
            start = (m_phase == M_PLAY && m_e == extra_at) || (start_in_done && m_phase == M_DONE);
            tick();
            lat++;
            if (done === 1'b1) begin
                dcnt++;
                if (dlat < 0) dlat = lat;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        check_eq("timeout", 32'(guard < 1000), 32'd1);
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        int dcnt;
        int dlat;
        int lv_len;
        logic [2:0]  lv;
        logic [47:0] pat;

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        level = 3'd1;
        seq   = '0;
        model_reset();
        #2 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        compare();
        tick();
        rst = 1'b1;
        tick();

        // Directed pattern {3,0,7,5}
        pat = '0;
        pat[11:0] = {3'd5, 3'd7, 3'd0, 3'd3};
        play(3'd1, pat, 1'b0, -1, -1, -1, 1'b0, dcnt, dlat);
        check_eq("t1_done_cnt", 32'(dcnt), 32'd1);
        check_eq("t1_done_lat", 32'(dlat), 32'(4*CYC + 1));

        // Level 3 with pattern scrambled during play
        play(3'd3, {16'($urandom), $urandom}, 1'b1, -1, -1, -1, 1'b0, dcnt, dlat);
        check_eq("t2_done_cnt", 32'(dcnt), 32'd1);
        check_eq("t2_done_lat", 32'(dlat), 32'(12*CYC + 1));

        // Abort in step 2 ON, then a fresh replay
        pat = {16'($urandom), $urandom};
        play(3'd2, pat, 1'b0, 2*CYC + 5, -1, -1, 1'b0, dcnt, dlat);
        check_eq("t3_no_done", 32'(dcnt), 32'd0);
        play(3'd2, pat, 1'b0, -1, -1, -1, 1'b0, dcnt, dlat);
        check_eq("t3_replay_done", 32'(dcnt), 32'd1);

        // Start during ON and in the DONE cycle is ignored
        play(3'd1, {16'($urandom), $urandom}, 1'b0, -1, -1, 10, 1'b1, dcnt, dlat);
        check_eq("t4_done_cnt", 32'(dcnt), 32'd1);
        check_eq("t4_done_lat", 32'(dlat), 32'(4*CYC + 1));

        // Async reset mid-OFF of step 5
        play(3'd2, {16'($urandom), $urandom}, 1'b0, -1, 5*CYC + 27, -1, 1'b0, dcnt, dlat);
        check_eq("t5_no_done", 32'(dcnt), 32'd0);

        // Level clamping at both ends
        play(3'd0, {16'($urandom), $urandom}, 1'b0, -1, -1, -1, 1'b0, dcnt, dlat);
        check_eq("t6_l0_lat", 32'(dlat), 32'(4*CYC + 1));
        play(3'd7, {16'($urandom), $urandom}, 1'b0, -1, -1, -1, 1'b0, dcnt, dlat);
        check_eq("t6_l7_lat", 32'(dlat), 32'(16*CYC + 1));

        // Abort together with start in IDLE stays idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();

        // Randomized plays
        for (int r = 0; r < 10; r++) begin
            int ab;
            int ex;
            lv     = 3'($urandom_range(0, 7));
            lv_len = len_of(lv);
            ab     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lv_len*CYC - 1)) : -1;
            ex     = int'($urandom_range(0, lv_len*CYC - 1));
            play(lv, {16'($urandom), $urandom}, 1'b1, ab, -1, ex, 1'($urandom_range(0, 1)), dcnt, dlat);
            if (ab < 0) begin
                check_eq("rnd_done_cnt", 32'(dcnt), 32'd1);
                check_eq("rnd_done_lat", 32'(dlat), 32'(lv_len*CYC + 1));
            end else begin
                check_eq("rnd_abort_done", 32'(dcnt), 32'd0);
            end
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                abort = 1'($urandom_range(0, 1));
                tick();
            end
            abort = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sequence_player
`default_nettype wire
